// File: rtl/pc_ctrl_if.sv
// Bus between the PC sequencer and its surroundings: decoded controls in,
// LUT index/target pair, and the sequencer status outputs.
interface pc_ctrl_if #(
  parameter int unsigned D = 12,
  parameter int unsigned A = 8,
  parameter int unsigned C = 16
);
  logic         start;
  logic         halt;
  logic         jump_en;
  logic         branch_en;
  logic         call_en;
  logic         ret_en;
  logic [A-1:0] lut_idx;
  logic [A-1:0] lut_addr;
  logic [D-1:0] lut_target;
  logic [D-1:0] pc;
  logic         fetch_valid;
  logic         done;
  logic         stk_err;
  logic [C-1:0] taken_cnt;

  // Driver side: decoder plus the target LUT.
  modport master (
    output start, halt, jump_en, branch_en, call_en, ret_en, lut_idx, lut_target,
    input  lut_addr, pc, fetch_valid, done, stk_err, taken_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, halt, jump_en, branch_en, call_en, ret_en, lut_idx, lut_target,
    output lut_addr, pc, fetch_valid, done, stk_err, taken_cnt
  );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter sequencer: IDLE/RUN/DONE state machine, PC register,
// return-address stack and saturating taken-transfer counter.
// The connected interface must use the same D/A/C as this module.
module pc_ctrl #(
  parameter int unsigned D = 12,
  parameter int unsigned A = 8,
  parameter int unsigned S = 4,  // power of 2, at least 2
  parameter int unsigned C = 16
) (
  input logic       clk,
  input logic       reset,
  pc_ctrl_if.slave  bus
);
  localparam int unsigned PW = $clog2(S);
  localparam logic [PW:0] Full = (PW+1)'(S);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t       state_q;
  logic [D-1:0] pc_q;
  logic [D-1:0] stk_q [S];
  logic [PW:0]  depth_q;
  logic         err_q;
  logic [C-1:0] cnt_q;
  logic         done_q;
  logic         fv_q;

  logic [D-1:0]  pc_inc;
  logic [PW-1:0] push_idx;
  logic [PW-1:0] pop_idx;
  logic          stk_full;
  logic          stk_empty;
  logic [C-1:0]  cnt_inc;

  // Datapath helpers: sequential PC, stack pointers, saturating count.
  always_comb begin
    pc_inc    = pc_q + D'(1);
    push_idx  = depth_q[PW-1:0];
    pop_idx   = push_idx - PW'(1);
    stk_full  = (depth_q == Full);
    stk_empty = (depth_q == '0);
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + C'(1);
  end

  // Sequencer FSM; start restarts from any state and overrides all controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fv_q    <= 1'b0;
      for (int i = 0; i < int'(S); i++) stk_q[i] <= '0;
    end else if (bus.start) begin
      state_q <= StRun;
      pc_q    <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fv_q    <= 1'b1;
    end else if (state_q == StRun) begin
      if (bus.halt) begin
        state_q <= StDone;
        done_q  <= 1'b1;
        fv_q    <= 1'b0;
      end else if (bus.ret_en) begin
        if (stk_empty) begin
          err_q   <= 1'b1;
          state_q <= StDone;
          done_q  <= 1'b1;
          fv_q    <= 1'b0;
        end else begin
          pc_q    <= stk_q[pop_idx];
          depth_q <= depth_q - (PW+1)'(1);
          cnt_q   <= cnt_inc;
        end
      end else if (bus.call_en) begin
        if (stk_full) begin
          err_q   <= 1'b1;
          state_q <= StDone;
          done_q  <= 1'b1;
          fv_q    <= 1'b0;
        end else begin
          stk_q[push_idx] <= pc_inc;
          pc_q    <= bus.lut_target;
          depth_q <= depth_q + (PW+1)'(1);
          cnt_q   <= cnt_inc;
        end
      end else if (bus.jump_en || bus.branch_en) begin
        pc_q  <= bus.lut_target;
        cnt_q <= cnt_inc;
      end else begin
        pc_q <= pc_inc;
      end
    end
  end

  assign bus.lut_addr    = bus.lut_idx;
  assign bus.pc          = pc_q;
  assign bus.fetch_valid = fv_q;
  assign bus.done        = done_q;
  assign bus.stk_err     = err_q;
  assign bus.taken_cnt   = cnt_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: per-scenario tasks, expected outputs
// queued as stimulus is driven and compared one cycle later.
module tb_pc_ctrl;
  localparam logic [5:0] N  = 6'b000000;
  localparam logic [5:0] ST = 6'b100000;
  localparam logic [5:0] H  = 6'b010000;
  localparam logic [5:0] R  = 6'b001000;
  localparam logic [5:0] CL = 6'b000100;
  localparam logic [5:0] J  = 6'b000010;
  localparam logic [5:0] B  = 6'b000001;

  typedef struct packed {
    logic [11:0] pc;
    logic        fv;
    logic        done;
    logic        err;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic [5:0] c;
    logic [7:0] idx;
    obs_t       e;
  } step_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  obs_t sb [$];

  always #5 clk = ~clk;

  pc_ctrl_if #(.D(12), .A(8), .C(16)) bus ();

  pc_ctrl #(.D(12), .A(8), .S(4), .C(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Bench target LUT.
  function automatic logic [11:0] lut_f(input logic [7:0] idx);
    case (idx)
      8'd3:    return 12'd328;
      8'd5:    return 12'd7;
      8'd10:   return 12'd145;
      8'd11:   return 12'd161;
      8'd12:   return 12'd177;
      8'd20:   return 12'd4095;
      default: return {4'h0, idx} + 12'd500;
    endcase
  endfunction

  always_comb bus.lut_target = lut_f(bus.lut_addr);

  function automatic obs_t mk(input int pc, input bit fv, input bit dn, input bit er,
                              input int cnt);
    obs_t o;
    o.pc = 12'(pc); o.fv = fv; o.done = dn; o.err = er; o.cnt = 16'(cnt);
    return o;
  endfunction

  function automatic obs_t run(input int pc, input int cnt);
    return mk(pc, 1'b1, 1'b0, 1'b0, cnt);
  endfunction

  function automatic step_t st(input logic [5:0] c, input logic [7:0] idx, input obs_t e);
    step_t s;
    s.c = c; s.idx = idx; s.e = e;
    return s;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc = bus.pc; o.fv = bus.fetch_valid; o.done = bus.done;
    o.err = bus.stk_err; o.cnt = bus.taken_cnt;
    return o;
  endfunction

  // Apply one cycle of controls, queue its expected result, step past the edge.
  task automatic drive(input logic [5:0] c, input logic [7:0] idx, input obs_t e);
    {bus.start, bus.halt, bus.ret_en, bus.call_en, bus.jump_en, bus.branch_en} = c;
    bus.lut_idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, e;
    step_t t [$];
    {bus.start, bus.halt, bus.ret_en, bus.call_en, bus.jump_en, bus.branch_en} = N;
    bus.lut_idx = '0;
    #1;
    got = sample(); n_run++;
    if (got !== mk(0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_async: got %h want %h", got, mk(0, 0, 0, 0, 0));
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    t.push_back(st(N, 0, mk(0, 0, 0, 0, 0)));
    t.push_back(st(J, 3, mk(0, 0, 0, 0, 0)));
    foreach (t[i]) begin
      drive(t[i].c, t[i].idx, t[i].e);
      got = sample(); e = sb.pop_front(); n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got pc=%0d fv=%b done=%b err=%b cnt=%0d want %0d,%b,%b,%b,%0d",
                 i, got.pc, got.fv, got.done, got.err, got.cnt, e.pc, e.fv, e.done, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_sequential();
    obs_t got, e;
    step_t t [$];
    t.push_back(st(ST, 0, run(0, 0)));
    t.push_back(st(N, 0, run(1, 0)));
    t.push_back(st(N, 0, run(2, 0)));
    foreach (t[i]) begin
      drive(t[i].c, t[i].idx, t[i].e);
      got = sample(); e = sb.pop_front(); n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL sequential[%0d]: got pc=%0d fv=%b done=%b err=%b cnt=%0d want %0d,%b,%b,%b,%0d",
                 i, got.pc, got.fv, got.done, got.err, got.cnt, e.pc, e.fv, e.done, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_jump();
    obs_t got, e;
    step_t t [$];
    bus.lut_idx = 8'd3;
    #1;
    n_run++;
    if (bus.lut_addr !== 8'd3) begin
      n_fail++;
      $display("FAIL lut_addr: got %0d want 3", bus.lut_addr);
    end
    t.push_back(st(J, 3, run(328, 1)));
    t.push_back(st(B, 5, run(7, 2)));
    t.push_back(st(J | B, 3, run(328, 3)));
    foreach (t[i]) begin
      drive(t[i].c, t[i].idx, t[i].e);
      got = sample(); e = sb.pop_front(); n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL jump[%0d]: got pc=%0d fv=%b done=%b err=%b cnt=%0d want %0d,%b,%b,%b,%0d",
                 i, got.pc, got.fv, got.done, got.err, got.cnt, e.pc, e.fv, e.done, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_call_ret();
    obs_t got, e;
    step_t t [$];
    t.push_back(st(ST, 0, run(0, 0)));  // restart from RUN
    for (int k = 1; k <= 10; k++) t.push_back(st(N, 0, run(k, 0)));
    t.push_back(st(CL, 10, run(145, 1)));
    t.push_back(st(CL, 11, run(161, 2)));
    t.push_back(st(CL, 12, run(177, 3)));
    t.push_back(st(R, 0, run(162, 4)));
    t.push_back(st(R, 0, run(146, 5)));
    t.push_back(st(R, 0, run(11, 6)));
    foreach (t[i]) begin
      drive(t[i].c, t[i].idx, t[i].e);
      got = sample(); e = sb.pop_front(); n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL call_ret[%0d]: got pc=%0d fv=%b done=%b err=%b cnt=%0d want %0d,%b,%b,%b,%0d",
                 i, got.pc, got.fv, got.done, got.err, got.cnt, e.pc, e.fv, e.done, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_stack_err();
    obs_t got, e;
    step_t t [$];
    t.push_back(st(ST, 0, run(0, 0)));
    for (int k = 1; k <= 4; k++) t.push_back(st(CL, 0, run(500, k)));
    t.push_back(st(CL, 0, mk(500, 0, 1, 1, 4)));   // overflow
    t.push_back(st(J, 3, mk(500, 0, 1, 1, 4)));    // DONE ignores controls
    t.push_back(st(ST, 0, run(0, 0)));             // restart from DONE
    t.push_back(st(R, 0, mk(0, 0, 1, 1, 0)));      // underflow
    foreach (t[i]) begin
      drive(t[i].c, t[i].idx, t[i].e);
      got = sample(); e = sb.pop_front(); n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL stack_err[%0d]: got pc=%0d fv=%b done=%b err=%b cnt=%0d want %0d,%b,%b,%b,%0d",
                 i, got.pc, got.fv, got.done, got.err, got.cnt, e.pc, e.fv, e.done, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_priority();
    obs_t got, e;
    step_t t [$];
    t.push_back(st(ST, 0, run(0, 0)));
    t.push_back(st(N, 0, run(1, 0)));
    t.push_back(st(H | J | CL, 10, mk(1, 0, 1, 0, 0)));
    t.push_back(st(ST | H | R, 10, run(0, 0)));    // start beats all controls
    t.push_back(st(N, 0, run(1, 0)));
    t.push_back(st(CL | J, 10, run(145, 1)));
    t.push_back(st(R | CL | J, 3, run(2, 2)));     // ret beats call; pops pushed 2
    foreach (t[i]) begin
      drive(t[i].c, t[i].idx, t[i].e);
      got = sample(); e = sb.pop_front(); n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL priority[%0d]: got pc=%0d fv=%b done=%b err=%b cnt=%0d want %0d,%b,%b,%b,%0d",
                 i, got.pc, got.fv, got.done, got.err, got.cnt, e.pc, e.fv, e.done, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t got, e;
    step_t t [$];
    t.push_back(st(ST, 0, run(0, 0)));
    t.push_back(st(J, 20, run(4095, 1)));
    t.push_back(st(N, 0, run(0, 1)));
    t.push_back(st(N, 0, run(1, 1)));
    foreach (t[i]) begin
      drive(t[i].c, t[i].idx, t[i].e);
      got = sample(); e = sb.pop_front(); n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got pc=%0d fv=%b done=%b err=%b cnt=%0d want %0d,%b,%b,%b,%0d",
                 i, got.pc, got.fv, got.done, got.err, got.cnt, e.pc, e.fv, e.done, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, e;
    step_t t [$];
    drive(ST, 0, run(0, 0));
    void'(sb.pop_front());
    drive(CL, 10, run(145, 1));
    void'(sb.pop_front());
    #2 reset = 1'b1;
    #1;
    got = sample(); n_run++;
    if (got !== mk(0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_mid: got %h want %h", got, mk(0, 0, 0, 0, 0));
    end
    @(posedge clk);
    #2 reset = 1'b0;
    t.push_back(st(N, 0, mk(0, 0, 0, 0, 0)));
    t.push_back(st(ST, 0, run(0, 0)));
    t.push_back(st(R, 0, mk(0, 0, 1, 1, 0)));  // stack was discarded
    foreach (t[i]) begin
      drive(t[i].c, t[i].idx, t[i].e);
      got = sample(); e = sb.pop_front(); n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got pc=%0d fv=%b done=%b err=%b cnt=%0d want %0d,%b,%b,%b,%0d",
                 i, got.pc, got.fv, got.done, got.err, got.cnt, e.pc, e.fv, e.done, e.err, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_call_ret();
    test_stack_err();
    test_priority();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter sequencer for the single-cycle core. It owns the PC register and a start/run/done state machine. It resolves each cycle's next PC from the decoded control of the current instruction: sequential, LUT-indexed jump/branch, call or return. A small return-address stack backs call/return. Branch targets come from the branch-target lookup table through a pass-through index/target pair.

## Interface
- D, 12, PC / target width
- A, 8, target-LUT index width
- S, 4, return-stack depth (entries, power of 2)
- C, 16, taken-transfer counter width

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  level; launches or restarts the program at PC 0
- halt  in  1  decoded halt of the current instruction
- jump_en  in  1  unconditional transfer to LUT target
- branch_en  in  1  conditional branch, already resolved taken
- call_en  in  1  push return address, transfer to LUT target
- ret_en  in  1  pop return address into PC
- lut_idx  in  A  target index from the instruction
- lut_addr  out  A  index to the target LUT (combinational = lut_idx)
- lut_target  in  D  target returned by the LUT (combinational)
- pc  out  D  current instruction address (registered)
- fetch_valid  out  1  high while in RUN
- done  out  1  registered, high in DONE
- stk_err  out  1  sticky stack overflow/underflow flag
- taken_cnt  out  C  count of taken transfers since start, saturating

## Operation
- States: IDLE, RUN, DONE.
- IDLE: pc=0, fetch_valid=0, done=0. start=1 → RUN next edge with pc=0, stack empty, stk_err=0, taken_cnt=0.
- RUN: controls apply to the instruction at the current pc. Next-PC priority: halt > ret_en > call_en > (jump_en | branch_en) > pc+1.
  - halt: → DONE, pc holds.
  - ret_en, stack non-empty: pc ← top, pop.
  - ret_en, stack empty: stk_err←1, → DONE, pc holds.
  - call_en, stack not full: push pc+1 (mod 2^D), pc ← lut_target.
  - call_en, stack full: stk_err←1, → DONE, pc holds, no push.
  - jump_en|branch_en: pc ← lut_target.
  - None of the above: pc ← pc+1. 2^D−1 wraps to 0 silently.
- taken_cnt increments on every executed jump, branch, call or ret. It holds at 2^C−1. halt and error cases do not count.
- start=1 in RUN or DONE: full restart, same as the IDLE launch. It overrides all controls that cycle.
- DONE: done=1, fetch_valid=0. pc, taken_cnt and stk_err hold. Controls are ignored. Stays in DONE until start or reset.
- lut_addr = lut_idx always, independent of state.
- Stack: S entries of D bits, depth counter 0..S. Simultaneous push/pop is impossible by priority.
- Control inputs are ignored outside RUN.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, pc=0, done=0, fetch_valid=0, stk_err=0, taken_cnt=0, stack depth=0.
- Next PC is combinational from the controls and lut_target in the same cycle. pc updates on the next rising edge: one-cycle transfer latency, no delay slot.
- LUT path: lut_idx → lut_addr → lut_target → next-pc mux, all in the same cycle.
- done rises on the edge after halt or error is sampled. fetch_valid falls on that same edge.
- start sampled at edge N: pc=0 and fetch_valid=1 after edge N. The instruction at 0 executes in cycle N+1.
- reset mid-RUN: immediate return to IDLE. The stack is discarded.

## Test plan
- Reset, then start pulse: pc=0 and fetch_valid=1 after one edge. With no controls, pc steps 0,1,2,3 on successive cycles. done=0, taken_cnt=0.
- At pc=2, jump_en with lut_idx=3 and the bench LUT returning 328: next pc=328, lut_addr=3, taken_cnt=1. Then branch_en with target 7 → pc=7, taken_cnt=2.
- call at pc=10 (target 145) → pc=145. Nested calls at 145 (→161) and 161 (→177), then three ret_en: pc=162, then 146, then 11.
- S+1=5 nested calls: 5th call sets stk_err=1, DONE next edge, pc holds. ret_en at depth 0 from a fresh start: stk_err=1, done=1.
- Priority: halt+jump_en+call_en in one cycle → DONE, pc unchanged, taken_cnt unchanged. call_en+jump_en → call taken (push occurs).
- pc=4095 with no control → pc=0. start asserted in DONE → RUN, pc=0, stk_err=0, taken_cnt=0. reset asserted mid-RUN between edges → outputs at reset values immediately.
